// File: rtl/sr_flipflop_bank.sv
// sr_flipflop_bank: a bank of WIDTH edge-triggered SR flip-flops with one shared
// clock enable. Each channel has a configurable S=R=1 policy. A sticky flag and a
// saturating counter record cycles in which a channel saw both set and reset.

// Per-channel next-state decode. This block is purely combinational, and the
// bank registers its result.
module sr_ff_lane #(
    parameter int CONFLICT_MODE = 0
) (
    input  logic i_q,
    input  logic i_s,
    input  logic i_r,
    output logic o_d
);

    // Select the next value from {s,r}. S=R=1 follows the configured policy.
    always_comb begin
        o_d = i_q;
        case ({i_s, i_r})
            2'b10: o_d = 1'b1;
            2'b01: o_d = 1'b0;
            2'b11: begin
                case (CONFLICT_MODE)
                    1:       o_d = 1'b1;
                    2:       o_d = 1'b0;
                    3:       o_d = ~i_q;
                    default: o_d = i_q;
                endcase
            end
            default: o_d = i_q;
        endcase
    end

endmodule

module sr_flipflop_bank #(
    parameter int              WIDTH         = 8,
    parameter int              CONFLICT_MODE = 0,
    parameter int              CNT_WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [WIDTH-1:0]     s,
    input  logic [WIDTH-1:0]     r,
    input  logic                 clr_flag,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qbar,
    output logic                 conflict,
    output logic [CNT_WIDTH-1:0] conflict_cnt,
    output logic                 changed
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]     r_q;
    logic                 r_changed;
    logic                 r_conflict;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0]     w_d;
    logic                 w_hit;

    // Each channel gets its own decoder instance.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        sr_ff_lane #(.CONFLICT_MODE(CONFLICT_MODE)) u_lane (
            .i_q (r_q[gi]),
            .i_s (s[gi]),
            .i_r (r[gi]),
            .o_d (w_d[gi])
        );
    end

    assign w_hit = en & (|(s & r));

    // Flip-flop state and the change pulse. A frozen (en=0) cycle never pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= RESET_VAL;
            r_changed <= 1'b0;
        end else if (en) begin
            r_q       <= w_d;
            r_changed <= (w_d != r_q);
        end else begin
            r_changed <= 1'b0;
        end
    end

    // Conflict monitor. clr_flag works independently of en. A hit that lands
    // in the same cycle as a clear is still recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict <= 1'b0;
            r_cnt      <= '0;
        end else if (clr_flag) begin
            r_conflict <= w_hit;
            r_cnt      <= w_hit ? CNT_WIDTH'(1) : '0;
        end else if (w_hit) begin
            r_conflict <= 1'b1;
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign q            = r_q;
    assign qbar         = ~r_q;
    assign conflict     = r_conflict;
    assign conflict_cnt = r_cnt;
    assign changed      = r_changed;

endmodule

// File: tb/tb_sr_flipflop_bank.sv
// Directed bench for sr_flipflop_bank. It has four instances with CNT_WIDTH=8,
// one per conflict mode, and a fifth instance (mode 1, CNT_WIDTH=2) for
// counter saturation. All instances share the same inputs.
module tb_sr_flipflop_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] s = '0;
    logic [7:0] r = '0;
    logic       clr_flag = 1'b0;

    logic [7:0] q    [5];
    logic [7:0] qb   [5];
    logic       cf   [5];
    logic       ch   [5];
    logic [7:0] cnt  [4];
    logic [1:0] cnt4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        sr_flipflop_bank #(.WIDTH(8), .CONFLICT_MODE(m), .CNT_WIDTH(8), .RESET_VAL(8'h00)) u_dut (
            .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_flag(clr_flag),
            .q(q[m]), .qbar(qb[m]), .conflict(cf[m]), .conflict_cnt(cnt[m]), .changed(ch[m])
        );
    end

    sr_flipflop_bank #(.WIDTH(8), .CONFLICT_MODE(1), .CNT_WIDTH(2), .RESET_VAL(8'h00)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_flag(clr_flag),
        .q(q[4]), .qbar(qb[4]), .conflict(cf[4]), .conflict_cnt(cnt4), .changed(ch[4])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // power-on reset state
        #1;
        for (int m = 0; m < 4; m++) begin
            total++; if (q[m] !== 8'h00)  begin bad++; $display("FAIL reset_q m%0d got=%h exp=00", m, q[m]); end
            total++; if (qb[m] !== 8'hFF) begin bad++; $display("FAIL reset_qbar m%0d got=%h exp=FF", m, qb[m]); end
            total++; if (cf[m] !== 1'b0 || cnt[m] !== 8'h00 || ch[m] !== 1'b0)
                begin bad++; $display("FAIL reset_flags m%0d got cf=%b cnt=%0d ch=%b exp 0/0/0", m, cf[m], cnt[m], ch[m]); end
        end
        #2 rst_n = 1'b1;
        // load A5, then a conflict on bit0 (mode 0 holds A5)
        en = 1'b1; s = 8'hA5; r = 8'h5A; step();
        s = 8'h01; r = 8'h01; step();
        total++; if (q[0] !== 8'hA5 || cf[0] !== 1'b1 || cnt[0] !== 8'd1)
            begin bad++; $display("FAIL pre_reset got q=%h cf=%b cnt=%0d exp A5/1/1", q[0], cf[0], cnt[0]); end
        // asynchronous reset mid-cycle, checked before any clock edge
        s = '0; r = '0; en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 4; m++) begin
            total++; if (q[m] !== 8'h00 || qb[m] !== 8'hFF || cf[m] !== 1'b0 || cnt[m] !== 8'h00 || ch[m] !== 1'b0)
                begin bad++; $display("FAIL async_reset m%0d got q=%h qb=%h cf=%b cnt=%0d ch=%b exp 00/FF/0/0/0",
                                      m, q[m], qb[m], cf[m], cnt[m], ch[m]); end
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_enable();
        en = 1'b0; s = 8'hFF; r = 8'h00;
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (q[0] !== 8'h00 || ch[0] !== 1'b0)
                begin bad++; $display("FAIL en_off_hold k%0d got q=%h ch=%b exp 00/0", k, q[0], ch[0]); end
        end
        en = 1'b1; step();
        for (int m = 0; m < 4; m++) begin
            total++; if (q[m] !== 8'hFF || ch[m] !== 1'b1)
                begin bad++; $display("FAIL en_on_set m%0d got q=%h ch=%b exp FF/1", m, q[m], ch[m]); end
        end
        s = 8'h00; step();
        total++; if (q[0] !== 8'hFF || ch[0] !== 1'b0)
            begin bad++; $display("FAIL changed_pulse got q=%h ch=%b exp FF/0", q[0], ch[0]); end
    endtask

    task automatic test_mixed();
        en = 1'b1; s = 8'hF0; r = 8'h0F; step();
        total++; if (q[0] !== 8'hF0) begin bad++; $display("FAIL mixed_load got=%h exp=F0", q[0]); end
        s = 8'h0F; r = 8'hF0; step();
        total++; if (q[0] !== 8'h0F || qb[0] !== 8'hF0 || ch[0] !== 1'b1 || cnt[0] !== 8'd0)
            begin bad++; $display("FAIL mixed_swap got q=%h qb=%h ch=%b cnt=%0d exp 0F/F0/1/0", q[0], qb[0], ch[0], cnt[0]); end
        s = 8'h00; r = 8'h00; step();
        total++; if (q[0] !== 8'h0F || ch[0] !== 1'b0)
            begin bad++; $display("FAIL mixed_hold got q=%h ch=%b exp 0F/0", q[0], ch[0]); end
    endtask

    task automatic test_modes();
        logic [7:0] exp_q [4];
        logic       exp_ch[4];
        exp_q  = '{8'h3C, 8'hBD, 8'h3C, 8'hBD};
        exp_ch = '{1'b0, 1'b1, 1'b0, 1'b1};
        en = 1'b1; s = 8'h3C; r = 8'hC3; clr_flag = 1'b1; step();
        clr_flag = 1'b0; s = 8'h81; r = 8'h81; step();
        for (int m = 0; m < 4; m++) begin
            total++; if (q[m] !== exp_q[m] || qb[m] !== ~exp_q[m])
                begin bad++; $display("FAIL mode_q m%0d got q=%h qb=%h exp q=%h", m, q[m], qb[m], exp_q[m]); end
            total++; if (cf[m] !== 1'b1 || cnt[m] !== 8'd1 || ch[m] !== exp_ch[m])
                begin bad++; $display("FAIL mode_flags m%0d got cf=%b cnt=%0d ch=%b exp 1/1/%b", m, cf[m], cnt[m], ch[m], exp_ch[m]); end
        end
        s = 8'h00; r = 8'h00;
    endtask

    task automatic test_saturate();
        logic [1:0] exp_c [5];
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        en = 1'b1; s = 8'h00; r = 8'h00; clr_flag = 1'b1; step();
        total++; if (cnt4 !== 2'd0 || cf[4] !== 1'b0)
            begin bad++; $display("FAIL sat_clr0 got cnt=%0d cf=%b exp 0/0", cnt4, cf[4]); end
        clr_flag = 1'b0; s = 8'h01; r = 8'h01;
        for (int k = 0; k < 5; k++) begin
            step();
            total++; if (cnt4 !== exp_c[k] || cf[4] !== 1'b1)
                begin bad++; $display("FAIL sat_count k%0d got cnt=%0d cf=%b exp %0d/1", k, cnt4, cf[4], exp_c[k]); end
        end
        total++; if (cnt[0] !== 8'd5) begin bad++; $display("FAIL wide_count got=%0d exp=5", cnt[0]); end
        clr_flag = 1'b1; step();
        total++; if (cnt4 !== 2'd1 || cf[4] !== 1'b1 || cnt[0] !== 8'd1)
            begin bad++; $display("FAIL clr_with_hit got cnt=%0d cf=%b wide=%0d exp 1/1/1", cnt4, cf[4], cnt[0]); end
        s = 8'h00; r = 8'h00; step();
        total++; if (cnt4 !== 2'd0 || cf[4] !== 1'b0 || cnt[0] !== 8'd0 || cf[0] !== 1'b0)
            begin bad++; $display("FAIL clr_alone got cnt=%0d cf=%b wide=%0d/%b exp 0/0/0/0", cnt4, cf[4], cnt[0], cf[0]); end
        clr_flag = 1'b0;
    endtask

    task automatic test_en_off_conflict();
        en = 1'b1; s = 8'h55; r = 8'hAA; step();
        s = 8'h02; r = 8'h02; step();
        en = 1'b0; s = 8'hFF; r = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (q[0] !== 8'h55 || q[3] !== 8'h57 || cnt[0] !== 8'd1 || cf[0] !== 1'b1 || ch[3] !== 1'b0)
                begin bad++; $display("FAIL en_off_conflict k%0d got q0=%h q3=%h cnt=%0d cf=%b ch=%b exp 55/57/1/1/0",
                                      k, q[0], q[3], cnt[0], cf[0], ch[3]); end
        end
        clr_flag = 1'b1; step();
        total++; if (cnt[0] !== 8'd0 || cf[0] !== 1'b0 || q[1] !== 8'h57)
            begin bad++; $display("FAIL clr_en_off got cnt=%0d cf=%b q1=%h exp 0/0/57", cnt[0], cf[0], q[1]); end
        clr_flag = 1'b0;
    endtask

    initial begin
        test_reset();
        test_enable();
        test_mixed();
        test_modes();
        test_saturate();
        test_en_off_conflict();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
